main_slave_loader: RTL and testbench
====================================

MAIN_SLAVE_LOADER -- requirements
Module: main_slave_loader

Interface
REQ-001 Parameter MEMSIZE, default 64: bytes of kernel memory preloaded and read back (1..65535).
REQ-002 Parameter TIMEOUT_CYCLES, default 200000000: run-phase watchdog limit.
REQ-003 Parameter BASE_ADDR, default 0: first slave byte address.
REQ-004 clock  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  upstream byte valid.
REQ-007 in_ready  out  1  loader accepts byte.
REQ-008 in_data  in  8  preload byte.
REQ-009 in_last  in  1  final preload byte.
REQ-010 start_port  out  1  one-cycle kernel start pulse.
REQ-011 done_port  in  1  kernel completion.
REQ-012 S_oe_ram  out  2  slave read enable; only bit 0 used, bit 1 tied 0.
REQ-013 S_we_ram  out  2  slave write enable; only bit 0 used, bit 1 tied 0.
REQ-014 S_addr_ram  out  16  slave address, channel 0 in [7:0].
REQ-015 S_Wdata_ram  out  128  write data; byte in [7:0], rest 0.
REQ-016 S_data_ram_size  out  14  access size; 8 when accessing, else 0.
REQ-017 Sout_Rdata_ram  in  128  read data; byte in [7:0].
REQ-018 Sout_DataRdy  in  2  access acknowledge; bit 0 used.
REQ-019 out_valid / out_ready / out_data[7:0] / out_last: downstream readback byte stream.
REQ-020 cycles  out  32  kernel latency of last run.
REQ-021 timeout  out  1  last run hit TIMEOUT_CYCLES.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 States: IDLE, LOAD, WACK, START, RUN, READ, RACK, EMIT.
REQ-024 IDLE: in_ready=1; accepted byte (in_valid&in_ready) -> LOAD with byte and last flag latched, idx=0.
REQ-025 LOAD: S_we_ram[0]=1 for exactly one cycle, S_addr_ram=BASE_ADDR+idx, S_Wdata_ram[7:0]=byte; -> WACK.
REQ-026 WACK: in_ready=0 until Sout_DataRdy[0]; on ack: if last flag or idx==MEMSIZE-1 -> START, loaded count=idx+1; else in_ready=1, next accepted byte -> LOAD with idx+1.
REQ-027 Bytes beyond MEMSIZE never accepted; in_last on any byte ends the load early.
REQ-028 START: start_port=1 for one cycle, run counter cleared to 0; -> RUN.
REQ-029 RUN: counter increments every cycle; done_port sampled high -> cycles=counter+1, timeout=0; done in first RUN cycle gives cycles=1.
REQ-030 RUN: counter+1==TIMEOUT_CYCLES without done -> cycles=TIMEOUT_CYCLES, timeout=1, -> IDLE (no readback).
REQ-031 READ: S_oe_ram[0]=1 one cycle at BASE_ADDR+ridx; -> RACK; RACK waits Sout_DataRdy[0], captures Sout_Rdata_ram[7:0] -> EMIT.
REQ-032 EMIT: out_valid=1, data stable until out_ready; out_last=1 when ridx==loaded count-1; on handshake, last -> IDLE else ridx+1 -> READ.
REQ-033 Ack arriving in the same cycle as the enable is accepted (zero-wait slave).
REQ-034 Sout_DataRdy outside WACK/RACK and done_port outside RUN are ignored.
REQ-035 cycles and timeout hold until the next RUN completes.

Reset
REQ-036 reset asserted at any time, mid-operation included: state IDLE, all enables 0, start_port=0, out_valid=0, out_last=0, out_data=0, cycles=0, timeout=0, busy=0, idx=ridx=0; in_ready=1 once released.

Configuration
REQ-037 Macro MAIN_SLAVE_READBACK_EN: defined -> RUN completion enters READ per REQ-031..032.
REQ-038 Undefined -> RUN completion returns to IDLE; READ/RACK/EMIT absent, out_valid and out_last constant 0, S_oe_ram constant 0.

Verification
REQ-039 Reset then 4 bytes 0x0A,0x0B,0x0C,0x0D(last), zero-wait slave -> 4 one-cycle writes at addresses 0..3, then one start_port pulse.
REQ-040 done_port high on the 7th RUN cycle -> cycles=7, timeout=0.
REQ-041 Readback enabled, slave returns 0x01..0x04, out_ready toggling 1/0 -> out_data 01,02,03,04 held through stalls, out_last only on 04.
REQ-042 TIMEOUT_CYCLES=16, done never asserted -> timeout=1, cycles=16, IDLE, no S_oe_ram pulse.
REQ-043 MEMSIZE=64, 70 bytes offered without in_last -> exactly 64 writes, byte 65 not accepted (in_ready low) until the next IDLE.
REQ-044 reset asserted during WACK with slave ack pending -> next cycle all outputs at reset values; a fresh load then starts at address BASE_ADDR.

Source files
------------

// File: rtl/main_slave_loader.sv
// main_slave_loader: streams preload bytes into a slave RAM one write at a time,
// pulses the kernel start, times the kernel run against a watchdog and, when the
// optional readback is built in, streams the preloaded bytes back out.
// Build option: define MAIN_SLAVE_READBACK_EN to include the READ/RACK/EMIT path;
// without it a finished run returns straight to IDLE and the output stream is idle.
module main_slave_loader #(
   parameter int unsigned MEMSIZE        = 64,
   parameter int unsigned TIMEOUT_CYCLES = 200000000,
   parameter int unsigned BASE_ADDR      = 0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   output logic         start_port,
   input  logic         done_port,
   output logic [1:0]   S_oe_ram,
   output logic [1:0]   S_we_ram,
   output logic [15:0]  S_addr_ram,
   output logic [127:0] S_Wdata_ram,
   output logic [13:0]  S_data_ram_size,
   input  logic [127:0] Sout_Rdata_ram,
   input  logic [1:0]   Sout_DataRdy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         out_last,
   output logic [31:0]  cycles,
   output logic         timeout,
   output logic         busy
);

   localparam logic [15:0] LAST_IDX = 16'(MEMSIZE - 1);
   localparam logic [31:0] TMO      = 32'(TIMEOUT_CYCLES);
   localparam logic [7:0]  BASE8    = 8'(BASE_ADDR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WACK,
      S_START,
      S_RUN
`ifdef MAIN_SLAVE_READBACK_EN
      ,
      S_READ,
      S_RACK,
      S_EMIT
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  byte_q, byte_d;
   logic        last_q, last_d;
   logic [15:0] idx_q, idx_d;
   logic        acked_q, acked_d;
   logic [31:0] run_q, run_d;
   logic [31:0] cycles_q, cycles_d;
   logic        timeout_q, timeout_d;
`ifdef MAIN_SLAVE_READBACK_EN
   logic [15:0] loaded_q, loaded_d;
   logic [15:0] ridx_q, ridx_d;
   logic [7:0]  rdata_q, rdata_d;
`endif

   logic        we0, oe0, ack;
   logic [7:0]  addr8, wdata8;
   logic [31:0] run_inc;

   assign ack     = Sout_DataRdy[0];
   assign run_inc = run_q + 32'd1;

   // Next-state and slave/stream control decode.
   // acked_q remembers an ack seen while the FSM could not yet act on it
   // (same-cycle ack in LOAD/READ, or an ack in WACK while no byte is offered).
   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      last_d     = last_q;
      idx_d      = idx_q;
      acked_d    = acked_q;
      run_d      = run_q;
      cycles_d   = cycles_q;
      timeout_d  = timeout_q;
`ifdef MAIN_SLAVE_READBACK_EN
      loaded_d   = loaded_q;
      ridx_d     = ridx_q;
      rdata_d    = rdata_q;
`endif
      in_ready   = 1'b0;
      start_port = 1'b0;
      we0        = 1'b0;
      oe0        = 1'b0;
      addr8      = '0;
      wdata8     = '0;
      out_valid  = 1'b0;
      out_last   = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               byte_d  = in_data;
               last_d  = in_last;
               idx_d   = '0;
               acked_d = 1'b0;
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            we0     = 1'b1;
            addr8   = BASE8 + idx_q[7:0];
            wdata8  = byte_q;
            acked_d = ack;
            state_d = S_WACK;
         end

         S_WACK: begin
            if (acked_q || ack) begin
               if (last_q || (idx_q == LAST_IDX)) begin
`ifdef MAIN_SLAVE_READBACK_EN
                  loaded_d = idx_q + 16'd1;
`endif
                  state_d  = S_START;
               end else begin
                  in_ready = 1'b1;
                  acked_d  = 1'b1;
                  if (in_valid) begin
                     byte_d  = in_data;
                     last_d  = in_last;
                     idx_d   = idx_q + 16'd1;
                     acked_d = 1'b0;
                     state_d = S_LOAD;
                  end
               end
            end
         end

         S_START: begin
            start_port = 1'b1;
            run_d      = '0;
            state_d    = S_RUN;
         end

         S_RUN: begin
            if (done_port) begin
               cycles_d  = run_inc;
               timeout_d = 1'b0;
`ifdef MAIN_SLAVE_READBACK_EN
               ridx_d    = '0;
               acked_d   = 1'b0;
               state_d   = S_READ;
`else
               state_d   = S_IDLE;
`endif
            end else if (run_inc == TMO) begin
               cycles_d  = TMO;
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               run_d = run_inc;
            end
         end

`ifdef MAIN_SLAVE_READBACK_EN
         S_READ: begin
            oe0     = 1'b1;
            addr8   = BASE8 + ridx_q[7:0];
            acked_d = ack;
            if (ack) rdata_d = Sout_Rdata_ram[7:0];
            state_d = S_RACK;
         end

         S_RACK: begin
            if (acked_q || ack) begin
               if (!acked_q) rdata_d = Sout_Rdata_ram[7:0];
               state_d = S_EMIT;
            end
         end

         S_EMIT: begin
            out_valid = 1'b1;
            out_last  = (ridx_q == (loaded_q - 16'd1));
            if (out_ready) begin
               if (out_last) begin
                  state_d = S_IDLE;
               end else begin
                  ridx_d  = ridx_q + 16'd1;
                  acked_d = 1'b0;
                  state_d = S_READ;
               end
            end
         end
`endif

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         byte_q    <= '0;
         last_q    <= 1'b0;
         idx_q     <= '0;
         acked_q   <= 1'b0;
         run_q     <= '0;
         cycles_q  <= '0;
         timeout_q <= 1'b0;
`ifdef MAIN_SLAVE_READBACK_EN
         loaded_q  <= '0;
         ridx_q    <= '0;
         rdata_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         byte_q    <= byte_d;
         last_q    <= last_d;
         idx_q     <= idx_d;
         acked_q   <= acked_d;
         run_q     <= run_d;
         cycles_q  <= cycles_d;
         timeout_q <= timeout_d;
`ifdef MAIN_SLAVE_READBACK_EN
         loaded_q  <= loaded_d;
         ridx_q    <= ridx_d;
         rdata_q   <= rdata_d;
`endif
      end
   end

   assign S_we_ram        = {1'b0, we0};
   assign S_oe_ram        = {1'b0, oe0};
   assign S_addr_ram      = {8'h00, addr8};
   assign S_Wdata_ram     = {120'd0, wdata8};
   assign S_data_ram_size = (we0 || oe0) ? 14'd8 : 14'd0;
   assign cycles          = cycles_q;
   assign timeout         = timeout_q;
   assign busy            = (state_q != S_IDLE);

`ifdef MAIN_SLAVE_READBACK_EN
   assign out_data = rdata_q;
   logic unused_inputs;
   assign unused_inputs = ^{Sout_Rdata_ram[127:8], Sout_DataRdy[1]};
`else
   assign out_data = '0;
   logic unused_inputs;
   assign unused_inputs = ^{Sout_Rdata_ram, Sout_DataRdy[1], out_ready};
`endif

endmodule

// File: tb/tb_main_slave_loader.sv
// Randomized bench for main_slave_loader with a behavioural slave RAM, kernel
// done driver and output-stream scoreboard. Works with and without
// MAIN_SLAVE_READBACK_EN.
module tb_main_slave_loader;

   localparam int unsigned MEMSIZE = 64;
   localparam int unsigned TMO     = 16;
   localparam int unsigned BASE    = 5;
`ifdef MAIN_SLAVE_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic         clock, reset;
   logic         in_valid, in_ready, in_last;
   logic [7:0]   in_data;
   logic         start_port, done_port;
   logic [1:0]   S_oe_ram, S_we_ram, Sout_DataRdy;
   logic [15:0]  S_addr_ram;
   logic [127:0] S_Wdata_ram, Sout_Rdata_ram;
   logic [13:0]  S_data_ram_size;
   logic         out_valid, out_ready, out_last;
   logic [7:0]   out_data;
   logic [31:0]  cycles;
   logic         timeout, busy;

   main_slave_loader #(.MEMSIZE(MEMSIZE), .TIMEOUT_CYCLES(TMO), .BASE_ADDR(BASE)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .start_port(start_port), .done_port(done_port),
      .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
      .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
      .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .cycles(cycles), .timeout(timeout), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // ---------------- slave RAM model ----------------
   logic [7:0] smem [0:255];
   bit         zero_wait = 1'b1;
   int         scnt = 0;
   logic       sack_q = 1'b0;
   logic [7:0] srd_q = 8'h00;

   initial for (int i = 0; i < 256; i++) smem[i] = 8'h00;

   assign Sout_DataRdy   = {1'b0, zero_wait ? (S_we_ram[0] | S_oe_ram[0]) : sack_q};
   assign Sout_Rdata_ram = {120'd0, zero_wait ? smem[S_addr_ram[7:0]] : srd_q};

   always @(posedge clock) begin
      sack_q <= 1'b0;
      if (scnt > 0) begin
         scnt <= scnt - 1;
         if (scnt == 1) sack_q <= 1'b1;
      end
      if (S_we_ram[0]) smem[S_addr_ram[7:0]] <= S_Wdata_ram[7:0];
      if (!zero_wait && (S_we_ram[0] || S_oe_ram[0])) begin
         scnt  <= int'($urandom_range(3, 1));
         srd_q <= smem[S_addr_ram[7:0]];
      end
   end

   // ---------------- reference model state ----------------
   logic [15:0] exp_wr[$];     // {addr, data}
   logic [8:0]  exp_rd[$];     // {last, data}
   logic [7:0]  tx_data[$];
   int          tx_last_at;
   int          n_acc;
   int          wr_count = 0, rd_count = 0, st_count = 0, em_count = 0;
   logic [15:0] rd_addr_exp;
   bit          toggle_mode = 1'b1;
   logic [31:0] prev_cyc = 0;
   logic        prev_tmo = 0;

   function automatic int n_accept();
      int n = tx_data.size();
      if (tx_last_at >= 0 && tx_last_at + 1 < n) n = tx_last_at + 1;
      if (n > int'(MEMSIZE)) n = int'(MEMSIZE);
      return n;
   endfunction

   // write-side monitor
   initial begin
      logic we_prev = 1'b0;
      logic [15:0] e;
      forever begin
         @(negedge clock);
         if (!reset && S_we_ram[0]) begin
            wr_count++;
            check("we_one_cycle", 32'(we_prev), 0);
            if (exp_wr.size() == 0) begin
               check("wr_unexpected", exp_wr.size(), 1);
            end else begin
               e = exp_wr.pop_front();
               check("wr_addr", 32'(S_addr_ram), 32'(e[15:8]));
               check("wr_data", S_Wdata_ram[31:0], 32'(e[7:0]));
               check("wr_upper", 32'(|S_Wdata_ram[127:8]), 0);
               check("wr_size", 32'(S_data_ram_size), 8);
            end
         end
         if (!reset && S_oe_ram[0]) begin
            rd_count++;
            check("rd_addr", 32'(S_addr_ram), 32'(rd_addr_exp));
            check("rd_size", 32'(S_data_ram_size), 8);
            rd_addr_exp++;
         end
         if (!reset && start_port) st_count++;
         we_prev = S_we_ram[0];
      end
   end

   // output-stream scoreboard and out_ready driver
   initial begin
      out_ready = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset && out_valid) begin
            if (exp_rd.size() == 0) begin
               check("out_unexpected", exp_rd.size(), 1);
            end else begin
               check("out_data", 32'(out_data), 32'(exp_rd[0][7:0]));
               check("out_last", 32'(out_last), 32'(exp_rd[0][8]));
            end
         end
         out_ready = toggle_mode ? ~out_ready : 1'($urandom_range(1, 0));
         if (!reset && out_valid && out_ready) begin
            em_count++;
            if (exp_rd.size() > 0) void'(exp_rd.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_bytes();
      int guard;
      for (int i = 0; i < tx_data.size(); i++) begin
         if (i < n_acc) begin
            if ($urandom_range(3, 0) == 0) begin
               in_valid = 1'b0;
               @(negedge clock);
            end
            in_valid = 1'b1;
            in_data  = tx_data[i];
            in_last  = (i == tx_last_at);
            guard = 0;
            while (!in_ready && guard < 200) begin
               @(negedge clock);
               guard++;
            end
            check("accept_wait", 32'(guard < 200), 1);
            @(negedge clock);
            in_valid = 1'b0;
         end else begin
            // one byte past the accepted set: must stay blocked while busy
            in_valid = 1'b1;
            in_data  = tx_data[i];
            in_last  = 1'b0;
            guard = 0;
            while (busy && guard < 3000) begin
               check("in_blocked", 32'(in_ready), 0);
               @(negedge clock);
               guard++;
            end
            in_valid = 1'b0;
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic done_thread(input int d);
      int g = 0;
      while (!start_port && g < 2000) begin
         done_port = ($urandom_range(3, 0) == 0);   // ignored outside RUN
         @(negedge clock);
         g++;
      end
      done_port = 1'b0;
      check("start_seen", 32'(start_port), 1);
      check("cycles_hold", cycles, prev_cyc);
      check("timeout_hold", 32'(timeout), 32'(prev_tmo));
      if (d > 0) begin
         repeat (d) @(negedge clock);
         done_port = 1'b1;
         @(negedge clock);
         done_port = 1'b0;
      end
   endtask

   task automatic run_txn(input int d);
      bit          timed;
      logic [31:0] exp_cyc;
      int          n_rd, wr0, rd0, st0, em0, g;
      n_acc = n_accept();
      for (int i = 0; i < n_acc; i++) exp_wr.push_back({8'(BASE + i), tx_data[i]});
      timed   = (d == 0) || (d > int'(TMO));
      exp_cyc = timed ? TMO : 32'(d);
      n_rd    = (RB && !timed) ? n_acc : 0;
      for (int i = 0; i < n_rd; i++) exp_rd.push_back({(i == n_acc - 1), tx_data[i]});
      rd_addr_exp = 16'(BASE);
      wr0 = wr_count; rd0 = rd_count; st0 = st_count; em0 = em_count;
      fork
         drive_bytes();
         done_thread(d);
      join
      g = 0;
      while (busy && g < 3000) begin
         @(negedge clock);
         g++;
      end
      check("idle_reached", 32'(busy), 0);
      check("cycles", cycles, exp_cyc);
      check("timeout", 32'(timeout), 32'(timed));
      check("n_writes", 32'(wr_count - wr0), 32'(n_acc));
      check("n_starts", 32'(st_count - st0), 1);
      check("n_reads", 32'(rd_count - rd0), 32'(n_rd));
      check("n_emits", 32'(em_count - em0), 32'(n_rd));
      check("writes_left", exp_wr.size(), 0);
      check("outs_left", exp_rd.size(), 0);
      check("in_ready_idle", 32'(in_ready), 1);
      exp_wr.delete();
      exp_rd.delete();
      prev_cyc = exp_cyc;
      prev_tmo = timed;
   endtask

   task automatic reset_mid_wack();
      zero_wait = 1'b0;
      exp_wr.push_back({8'(BASE), 8'hEE});
      in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
      @(negedge clock);              // accepted; now in LOAD
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clock);              // WACK, ack still pending from the slave
      reset = 1'b1;
      @(negedge clock);
      check("rst_busy", 32'(busy), 0);
      check("rst_we", 32'(S_we_ram), 0);
      check("rst_oe", 32'(S_oe_ram), 0);
      check("rst_start", 32'(start_port), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_cycles", cycles, 0);
      check("rst_timeout", 32'(timeout), 0);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_wr_seen", exp_wr.size(), 0);
      exp_wr.delete();
      prev_cyc = 0;
      prev_tmo = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; done_port = 1'b0;
      repeat (3) @(negedge clock);
      check("init_busy", 32'(busy), 0);
      check("init_cycles", cycles, 0);
      check("init_timeout", 32'(timeout), 0);
      check("init_out_valid", 32'(out_valid), 0);
      check("init_start", 32'(start_port), 0);
      check("init_we", 32'(S_we_ram), 0);
      reset = 1'b0;
      @(negedge clock);
      check("init_in_ready", 32'(in_ready), 1);

      // 4 bytes, zero-wait slave, done on 7th RUN cycle
      zero_wait = 1'b1; toggle_mode = 1'b1;
      tx_data = '{8'h0A, 8'h0B, 8'h0C, 8'h0D}; tx_last_at = 3;
      run_txn(7);

      // readback payload 01..04 with alternating out_ready
      tx_data = '{8'h01, 8'h02, 8'h03, 8'h04}; tx_last_at = 3;
      run_txn(int'($urandom_range(16, 1)));

      // watchdog: done never asserted
      zero_wait = 1'b0;
      tx_data = '{8'h5A, 8'hA5, 8'h3C}; tx_last_at = 2;
      run_txn(0);

      // overflow: 70 bytes without in_last
      zero_wait = 1'b1; toggle_mode = 1'b0;
      tx_data.delete();
      for (int i = 0; i < 70; i++) tx_data.push_back(8'($urandom));
      tx_last_at = -1;
      run_txn(5);

      // reset during WACK, then a fresh load from BASE
      reset_mid_wack();
      tx_data = '{8'h11, 8'h22}; tx_last_at = 1;
      run_txn(3);

      // randomized transactions
      for (int t = 0; t < 10; t++) begin
         int len;
         zero_wait   = 1'($urandom_range(1, 0));
         toggle_mode = 1'($urandom_range(1, 0));
         len = int'($urandom_range(8, 1));
         tx_data.delete();
         for (int i = 0; i < len; i++) tx_data.push_back(8'($urandom));
         tx_last_at = int'($urandom_range(len - 1, 0));
         run_txn(int'($urandom_range(20, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
